// File: rtl/addsubmod_pipe.sv
// addsubmod_pipe: two-stage modular add/sub over a prime field with valid/ready on both sides.
module addsubmod_pipe #(
  parameter int WORD_SIZE = 381,
  parameter logic [WORD_SIZE-1:0] MODULUS = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic [WORD_SIZE-1:0] in_a,
  input  logic [WORD_SIZE-1:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_res,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int W2 = WORD_SIZE + 2;
  logic [W2-1:0]        w_p, w_a, w_b, w_sd, w_alt, w_sel;
  logic                 w_adv1, w_adv2, w_unused;
  logic                 r_v1, r_v2, r_op;
  logic [TAG_W-1:0]     r_tag1, r_tag2;
  logic [W2-1:0]        r_sd, r_alt;
  logic [WORD_SIZE-1:0] r_res;
  assign w_p   = {2'b00, MODULUS};
  assign w_a   = {2'b00, in_a};
  assign w_b   = {2'b00, in_b};
  assign w_sd  = in_op ? w_a - w_b : w_a + w_b;
  assign w_alt = in_op ? w_sd + w_p : w_sd - w_p;
  // add keeps s when s-p went negative; sub takes d+p when d went negative
  assign w_sel = r_op ? (r_sd[W2-1] ? r_alt : r_sd) : (r_alt[W2-1] ? r_sd : r_alt);
  assign w_unused = ^w_sel[W2-1:WORD_SIZE];
  assign w_adv2 = !r_v2 || out_ready;
  assign w_adv1 = !r_v1 || w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_v2;
  assign out_res   = r_res;
  assign out_tag   = r_tag2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_op   <= 1'b0;
      r_tag1 <= '0;
      r_sd   <= '0;
      r_alt  <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_op   <= in_op;
        r_tag1 <= in_tag;
        r_sd   <= w_sd;
        r_alt  <= w_alt;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_res  <= '0;
      r_tag2 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_res  <= w_sel[WORD_SIZE-1:0];
        r_tag2 <= r_tag1;
      end
    end
  end
endmodule

// File: tb/tb_addsubmod_pipe.sv
// tb_addsubmod_pipe: directed and randomized checks of addsubmod_pipe at 8-bit and full width.
module tb_addsubmod_pipe;
  localparam logic [380:0] BP = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic in_valid = 0, in_ready, in_op = 0, out_valid, out_ready = 1;
  logic [7:0] in_a = 0, in_b = 0, out_res;
  logic [3:0] in_tag = 0, out_tag;
  logic b_in_valid = 0, b_in_ready, b_in_op = 0, b_out_valid, b_out_ready = 1;
  logic [380:0] b_in_a = 0, b_in_b = 0, b_out_res;
  logic [7:0] b_in_tag = 0, b_out_tag;
  int errors = 0, checks = 0;
  addsubmod_pipe #(.WORD_SIZE(8), .MODULUS(8'd251), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag));
  addsubmod_pipe u_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_a(b_in_a), .in_b(b_in_b), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_res(b_out_res), .out_tag(b_out_tag));

  task automatic do_op(input logic op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag,
                       output logic [7:0] res, output logic [3:0] t, output int lat);
    @(negedge clk);
    out_ready = 1; in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = out_res;
    t = out_tag;
  endtask

  task automatic test_reset();
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_res !== 8'd0) begin errors++; $display("FAIL reset_out_res got=%0d exp=0", out_res); end
    if (out_tag !== 4'd0) begin errors++; $display("FAIL reset_out_tag got=%0d exp=0", out_tag); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_add();
    logic [7:0] va[3] = '{8'd200, 8'd100, 8'd250};
    logic [7:0] vb[3] = '{8'd100, 8'd151, 8'd250};
    logic [7:0] ve[3] = '{8'd49, 8'd0, 8'd249};
    logic [3:0] vt[3] = '{4'd3, 4'd9, 4'd14};
    logic [7:0] res; logic [3:0] t; int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, va[i], vb[i], vt[i], res, t, lat);
      checks += 3;
      if (res !== ve[i]) begin errors++; $display("FAIL add_res[%0d] got=%0d exp=%0d", i, res, ve[i]); end
      if (t !== vt[i]) begin errors++; $display("FAIL add_tag[%0d] got=%0d exp=%0d", i, t, vt[i]); end
      if (lat !== 2) begin errors++; $display("FAIL add_latency[%0d] got=%0d exp=2", i, lat); end
    end
  endtask

  task automatic test_sub();
    logic [7:0] va[4] = '{8'd5, 8'd77, 8'd0, 8'd250};
    logic [7:0] vb[4] = '{8'd10, 8'd77, 8'd250, 8'd0};
    logic [7:0] ve[4] = '{8'd246, 8'd0, 8'd1, 8'd250};
    logic [7:0] res; logic [3:0] t; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, va[i], vb[i], 4'(i + 5), res, t, lat);
      checks += 3;
      if (res !== ve[i]) begin errors++; $display("FAIL sub_res[%0d] got=%0d exp=%0d", i, res, ve[i]); end
      if (t !== 4'(i + 5)) begin errors++; $display("FAIL sub_tag[%0d] got=%0d exp=%0d", i, t, i + 5); end
      if (lat !== 2) begin errors++; $display("FAIL sub_latency[%0d] got=%0d exp=2", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ve[6] = '{8'd1, 8'd52, 8'd103, 8'd154, 8'd205, 8'd5};
    logic [7:0] prev_res = 0; logic [3:0] prev_tag = 0;
    logic stalled = 0;
    int sent = 0, got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      in_valid = sent < 6; in_op = 0; in_a = 8'(50 * sent); in_b = 8'(sent + 1); in_tag = 4'(sent);
      #1;
      if (c == 2 || c == 3) begin
        checks++;
        if (in_ready !== (c == 2)) begin errors++; $display("FAIL bp_in_ready[c%0d] got=%b exp=%b", c, in_ready, c == 2); end
      end
      if (stalled) begin
        checks++;
        if (out_res !== prev_res || out_tag !== prev_tag)
          begin errors++; $display("FAIL bp_stable[c%0d] got=%0d/%0d exp=%0d/%0d", c, out_res, out_tag, prev_res, prev_tag); end
      end
      if (out_valid && out_ready) begin
        checks += 2;
        if (out_res !== ve[got]) begin errors++; $display("FAIL bp_res[%0d] got=%0d exp=%0d", got, out_res, ve[got]); end
        if (out_tag !== 4'(got)) begin errors++; $display("FAIL bp_tag[%0d] got=%0d exp=%0d", got, out_tag, got); end
        got++;
      end
      stalled = out_valid && !out_ready;
      prev_res = out_res; prev_tag = out_tag;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 0; out_ready = 1;
    checks++;
    if (got !== 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res; logic [3:0] t; int lat; bit seen = 0;
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_op = 0; in_a = 1; in_b = 2; in_tag = 7;
    @(negedge clk);
    in_a = 3; in_tag = 8;
    @(negedge clk);
    in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rm_full got=%b%b exp=10", out_valid, in_ready); end
    #2 rst = 1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rm_stale got=1 exp=0"); end
    do_op(1'b1, 8'd9, 8'd4, 4'd2, res, t, lat);
    checks += 3;
    if (res !== 8'd5) begin errors++; $display("FAIL rm_res got=%0d exp=5", res); end
    if (t !== 4'd2) begin errors++; $display("FAIL rm_tag got=%0d exp=2", t); end
    if (lat !== 2) begin errors++; $display("FAIL rm_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_random();
    logic [11:0] q[$];
    logic [11:0] e;
    int a, b, r;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (c < 400) begin
        in_valid = $urandom_range(0, 3) != 0;
        out_ready = $urandom_range(0, 2) != 0;
      end else begin
        in_valid = 0; out_ready = 1;
      end
      a = $urandom_range(0, 250); b = $urandom_range(0, 250);
      in_op = $urandom_range(0, 1); in_a = 8'(a); in_b = 8'(b); in_tag = 4'(c);
      #1;
      if (in_valid && in_ready) begin
        r = in_op ? (a + 251 - b) % 251 : (a + b) % 251;
        q.push_back({4'(c), 8'(r)});
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_extra got=%0d exp=none", out_res); end
        else begin
          e = q.pop_front();
          if ({out_tag, out_res} !== e) begin errors++; $display("FAIL rnd[c%0d] got=%0d/%0d exp=%0d/%0d", c, out_tag, out_res, e[11:8], e[7:0]); end
        end
      end
    end
    in_valid = 0;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got=%0d exp=0", q.size()); end
  endtask

  task automatic test_full_width();
    logic [380:0] va[3] = '{BP - 1, 381'd1, 381'd0};
    logic [380:0] vb[3] = '{BP - 1, 381'd2, BP - 1};
    logic [380:0] ve[3] = '{BP - 2, BP - 1, 381'd1};
    logic vo[3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_in_valid = 1; b_in_op = vo[i]; b_in_a = va[i]; b_in_b = vb[i]; b_in_tag = 8'(40 + i);
      @(negedge clk);
      b_in_valid = 0;
      lat = 1;
      while (!b_out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks += 2;
      if (b_out_res !== ve[i]) begin errors++; $display("FAIL fw_res[%0d] got=%h exp=%h", i, b_out_res, ve[i]); end
      if (b_out_tag !== 8'(40 + i) || lat !== 2) begin errors++; $display("FAIL fw_tag_lat[%0d] got=%0d/%0d exp=%0d/2", i, b_out_tag, lat, 40 + i); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_full_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
